// File: rtl/pts_pkg.sv
// Shared types and constants for the polyphonic tone synthesiser.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pts_pkg;

    // Sequencer states: wait for tick, walk voices, clamp mix, wait for consumer.
    typedef enum logic [1:0] {
        PTS_IDLE = 2'd0,
        PTS_RUN  = 2'd1,
        PTS_SAT  = 2'd2,
        PTS_HOLD = 2'd3
    } pts_state_t;

    // Default tuning words for a 48 kHz sample tick and a 24-bit phase accumulator,
    // inc = round(f * 2^24 / 48000). Order: C4 C#4 D4 D#4 E4 F4 F#4 G4 G#4 A4 A#4 B4 C5 C#5 D5 D#5 E5.
    localparam int NOTE_CNT = 17;
    localparam logic [23:0] NOTE_INC [NOTE_CNT] = '{
        24'd91446,  24'd96883,  24'd102645, 24'd108748, 24'd115215, 24'd122066,
        24'd129322, 24'd137012, 24'd145160, 24'd153791, 24'd162936, 24'd172625,
        24'd182892, 24'd193767, 24'd205290, 24'd217497, 24'd230430
    };

    // First quadrant of a sine, entry i = round(32767 * sin(i * pi / 126)), so the
    // last entry hits the full positive peak and the mirrored quadrant reuses it.
    localparam int SINE_QTR_DEPTH = 64;
    localparam logic [15:0] SINE_QTR [SINE_QTR_DEPTH] = '{
        16'd0,     16'd817,   16'd1633,  16'd2449,  16'd3263,  16'd4074,  16'd4884,  16'd5690,
        16'd6493,  16'd7291,  16'd8086,  16'd8875,  16'd9658,  16'd10436, 16'd11207, 16'd11971,
        16'd12728, 16'd13477, 16'd14217, 16'd14949, 16'd15671, 16'd16384, 16'd17086, 16'd17778,
        16'd18458, 16'd19128, 16'd19785, 16'd20430, 16'd21062, 16'd21681, 16'd22287, 16'd22879,
        16'd23457, 16'd24020, 16'd24568, 16'd25101, 16'd25618, 16'd26120, 16'd26605, 16'd27073,
        16'd27525, 16'd27960, 16'd28377, 16'd28777, 16'd29158, 16'd29522, 16'd29867, 16'd30194,
        16'd30502, 16'd30791, 16'd31061, 16'd31311, 16'd31542, 16'd31754, 16'd31945, 16'd32117,
        16'd32269, 16'd32401, 16'd32513, 16'd32604, 16'd32675, 16'd32726, 16'd32757, 16'd32767
    };

    function automatic logic [15:0] sine_qtr_lookup(input logic [5:0] addr);
        return SINE_QTR[addr];
    endfunction

endpackage

// File: rtl/pts_voice_dp.sv
// Per-voice datapath: phase advance, linear envelope step, waveform select and gain multiply.
// Latency: purely combinational, result is consumed by the parent in the same cycle.
// Backpressure: none; the parent only presents a voice while it is walking the voice list.
// Build option PTS_SINE_EN selects a quarter-wave sine table instead of the square wave.
module pts_voice_dp
    import pts_pkg::*;
#(
    parameter int PHASE_W  = 24,
    parameter int AMP_W    = 16,
    parameter int ENV_STEP = 16
) (
    input  logic [PHASE_W-1:0]      phase_cur,
    input  logic [AMP_W-1:0]        env_cur,
    input  logic                    gate,
    input  logic [PHASE_W-1:0]      inc,
    output logic [PHASE_W-1:0]      phase_nxt,
    output logic [AMP_W-1:0]        env_nxt,
    output logic signed [AMP_W-1:0] voice_val
);

    localparam logic [AMP_W:0]          ENV_MAX = {1'b0, {AMP_W{1'b1}}};
    localparam logic [AMP_W:0]          STEP    = (AMP_W+1)'(ENV_STEP);
    localparam logic signed [AMP_W-1:0] WAVE_PK = {1'b0, {(AMP_W-1){1'b1}}};

    logic [AMP_W:0]           env_up;
    logic [AMP_W:0]           env_dn;
    logic signed [AMP_W-1:0]  wave;
    logic signed [2*AMP_W:0]  prod;

    // Phase wraps naturally at 2^PHASE_W.
    assign phase_nxt = phase_cur + inc;

    // One extra bit catches both the overshoot past full scale and the underflow past zero.
    assign env_up = {1'b0, env_cur} + STEP;
    assign env_dn = {1'b0, env_cur} - STEP;

    // Attack saturates at full scale, release saturates at zero.
    always_comb begin
        env_nxt = env_cur;
        if (gate) begin
            env_nxt = (env_up > ENV_MAX) ? ENV_MAX[AMP_W-1:0] : env_up[AMP_W-1:0];
        end else begin
            env_nxt = ({1'b0, env_cur} < STEP) ? '0 : env_dn[AMP_W-1:0];
        end
    end

`ifdef PTS_SINE_EN
    logic [5:0]       lut_addr;
    logic [AMP_W-1:0] lut_mag;

    // Second and fourth quadrants walk the table backwards.
    always_comb begin
        lut_addr = phase_nxt[PHASE_W-3 -: 6];
        if (phase_nxt[PHASE_W-2]) begin
            lut_addr = ~lut_addr;
        end
    end

    // Table is scaled for a 16-bit peak; rescale to the configured amplitude width.
    assign lut_mag = AMP_W'((64'(sine_qtr_lookup(lut_addr)) << AMP_W) >> 16);
    assign wave    = phase_nxt[PHASE_W-1] ? -$signed(lut_mag) : $signed(lut_mag);
`else
    // Square wave: sign of the phase picks the symmetric peak.
    assign wave = phase_nxt[PHASE_W-1] ? -WAVE_PK : WAVE_PK;
`endif

    // Envelope is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod      = wave * $signed({1'b0, env_nxt});
    assign voice_val = AMP_W'(prod >>> AMP_W);

endmodule

// File: rtl/poly_tone_synth.sv
// Time-multiplexed polyphonic synth: walks NUM_VOICES voices per tick and emits one clamped mix.
// Latency: tick sampled at edge t gives sample_valid after edge t+NUM_VOICES+1.
// Backpressure: sample held until sample_ready; ticks arriving while not idle are dropped, setting sticky overrun.
// Build option PTS_SINE_EN (see pts_voice_dp) switches the waveform to sine.
module poly_tone_synth
    import pts_pkg::*;
#(
    parameter int NUM_VOICES = 10,
    parameter int PHASE_W    = 24,
    parameter int AMP_W      = 16,
    parameter int OUT_W      = 32,
    parameter int ENV_STEP   = 16,
    parameter int MIX_SHIFT  = 0
) (
    input  logic                          Clk,
    input  logic                          reset_n,
    input  logic [NUM_VOICES-1:0]         key_on,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
    input  logic                          sample_tick,
    output logic signed [OUT_W-1:0]       sample_out,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overrun,
    output logic                          busy
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = AMP_W + $clog2(NUM_VOICES) + 1;
    localparam int SH_W  = ((ACC_W + MIX_SHIFT) > OUT_W) ? (ACC_W + MIX_SHIFT) : (OUT_W + 1);

    localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [SH_W-1:0] SAT_MIN = ~SAT_MAX;

    pts_state_t              state_q;
    pts_state_t              state_d;
    logic [VW-1:0]           vidx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
    logic [AMP_W-1:0]        env_q   [NUM_VOICES];
    logic [PHASE_W-1:0]      inc_arr [NUM_VOICES];

    logic                    last_voice;
    logic                    accept;
    logic [PHASE_W-1:0]      dp_phase;
    logic [AMP_W-1:0]        dp_env;
    logic signed [AMP_W-1:0] dp_voice;
    logic signed [SH_W-1:0]  mix_sh;
    logic [OUT_W-1:0]        sat_val;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_inc
        assign inc_arr[g] = phase_inc[g*PHASE_W +: PHASE_W];
    end

    assign last_voice = (vidx_q == VW'(NUM_VOICES - 1));
    assign accept     = sample_valid && sample_ready;
    assign busy       = (state_q == PTS_RUN) || (state_q == PTS_SAT);

    pts_voice_dp #(
        .PHASE_W  (PHASE_W),
        .AMP_W    (AMP_W),
        .ENV_STEP (ENV_STEP)
    ) u_voice_dp (
        .phase_cur (phase_q[vidx_q]),
        .env_cur   (env_q[vidx_q]),
        .gate      (key_on[vidx_q]),
        .inc       (inc_arr[vidx_q]),
        .phase_nxt (dp_phase),
        .env_nxt   (dp_env),
        .voice_val (dp_voice)
    );

    // Sequencer state register; reset aborts any sample in flight.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PTS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one voice per RUN cycle, one cycle to clamp, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PTS_IDLE: if (sample_tick) state_d = PTS_RUN;
            PTS_RUN:  if (last_voice)  state_d = PTS_SAT;
            PTS_SAT:                   state_d = PTS_HOLD;
            PTS_HOLD: if (accept)      state_d = PTS_IDLE;
            default:                   state_d = PTS_IDLE;
        endcase
    end

    // Write back the voice just processed into the phase/envelope banks.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                env_q[i]   <= '0;
            end
        end else if (state_q == PTS_RUN) begin
            phase_q[vidx_q] <= dp_phase;
            env_q[vidx_q]   <= dp_env;
        end
    end

    // Mix accumulator and voice pointer restart on every accepted tick.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            vidx_q <= '0;
        end else if (state_q == PTS_IDLE && sample_tick) begin
            acc_q  <= '0;
            vidx_q <= '0;
        end else if (state_q == PTS_RUN) begin
            acc_q  <= acc_q + ACC_W'(dp_voice);
            vidx_q <= vidx_q + 1'b1;
        end
    end

    // Scale the mix and clamp it to the output range.
    always_comb begin
        mix_sh  = SH_W'(acc_q) <<< MIX_SHIFT;
        sat_val = mix_sh[OUT_W-1:0];
        if (mix_sh > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (mix_sh < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
    end

    // Output register holds the sample steady until the consumer takes it.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else if (state_q == PTS_SAT) begin
            sample_out   <= $signed(sat_val);
            sample_valid <= 1'b1;
        end else if (state_q == PTS_HOLD && accept) begin
            sample_valid <= 1'b0;
        end
    end

    // Any tick that cannot start a new sample is lost; remember that until reset.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (sample_tick && state_q != PTS_IDLE) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Randomised bench for poly_tone_synth against an arithmetic reference of the synth rules.
// Latency: checks tick-to-valid distance on every sample.
// Backpressure: exercises held samples, dropped ticks and sticky overrun.
module tb_poly_tone_synth;

    localparam int NV   = 10;
    localparam int PW   = 24;
    localparam int STEP = 8192;
    localparam int MSH  = 14;

    logic                 Clk;
    logic                 reset_n;
    logic [NV-1:0]        key_on;
    logic [NV*PW-1:0]     phase_inc;
    logic                 sample_tick;
    logic signed [31:0]   sample_out;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 overrun;
    logic                 busy;

    int n_total = 0;
    int n_bad   = 0;

    longint m_phase [NV];
    longint m_env   [NV];
    bit     m_on    [NV];
    longint m_inc   [NV];
    bit     exp_ovr;
    longint last_exp;

    poly_tone_synth #(
        .NUM_VOICES (NV),
        .PHASE_W    (PW),
        .AMP_W      (16),
        .OUT_W      (32),
        .ENV_STEP   (STEP),
        .MIX_SHIFT  (MSH)
    ) dut (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .key_on       (key_on),
        .phase_inc    (phase_inc),
        .sample_tick  (sample_tick),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Advance every voice by one sample and return the clamped mixed output.
    function automatic longint model_sample();
        longint acc;
        longint wave;
        longint s;
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = (m_phase[v] + m_inc[v]) % (64'sd1 << PW);
            if (m_on[v]) m_env[v] = (m_env[v] + STEP > 65535) ? 65535 : m_env[v] + STEP;
            else         m_env[v] = (m_env[v] - STEP < 0) ? 0 : m_env[v] - STEP;
            wave = (m_phase[v] >= (64'sd1 << (PW - 1))) ? -32767 : 32767;
            acc += floor_div(wave * m_env[v], 65536);
        end
        s = acc * (64'sd1 << MSH);
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_env[v]   = 0;
        end
        exp_ovr = 1'b0;
    endtask

    task automatic apply_inputs();
        for (int v = 0; v < NV; v++) begin
            key_on[v]              = m_on[v];
            phase_inc[v*PW +: PW]  = m_inc[v][PW-1:0];
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One full tick-to-sample transaction; optionally fire a tick on the handshake cycle.
    task automatic do_sample(input bit hs_tick);
        longint exp;
        int lat;
        exp = model_sample();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk_val("busy_run", longint'(busy), 1);
        lat = 0;
        while (!sample_valid && lat < 40) begin
            step();
            lat++;
        end
        chk_val("latency", lat, NV + 1);
        chk_val("sample", longint'(sample_out), exp);
        chk_val("overrun", longint'(overrun), longint'(exp_ovr));
        last_exp = exp;
        if (sample_ready) begin
            if (hs_tick) sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            if (hs_tick) exp_ovr = 1'b1;
            chk_val("valid_clr", longint'(sample_valid), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int vcount;
        reset_n      = 1'b0;
        sample_tick  = 1'b0;
        sample_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            m_on[v]  = 1'b0;
            m_inc[v] = 0;
        end
        model_reset();
        apply_inputs();
        repeat (3) step();
        chk_val("rst_valid", longint'(sample_valid), 0);
        chk_val("rst_out",   longint'(sample_out), 0);
        reset_n = 1'b1;
        step();
        chk_val("rst_ovr",   longint'(overrun), 0);
        chk_val("rst_busy",  longint'(busy), 0);
        chk_val("rst_out2",  longint'(sample_out), 0);

        // Single square voice: envelope ramps, then sign follows the phase MSB.
        m_on[0]  = 1'b1;
        m_inc[0] = 64'd1 << 20;
        apply_inputs();
        for (int k = 1; k <= 16; k++) begin
            do_sample(1'b0);
            if (k == 8)  chk_val("sq_neg_peak", longint'(sample_out), -64'sd536854528);
            if (k == 16) chk_val("sq_pos_peak", longint'(sample_out), 64'sd536838144);
        end

        // Release: envelope decays to silence.
        m_on[0] = 1'b0;
        apply_inputs();
        for (int k = 0; k < 10; k++) do_sample(1'b0);
        chk_val("release_zero", longint'(sample_out), 0);

        // All voices loud and in tune: the mix clamps at the rails.
        for (int v = 0; v < NV; v++) begin
            m_on[v]  = 1'b1;
            m_inc[v] = 64'd1 << 20;
        end
        apply_inputs();
        for (int k = 0; k < 14; k++) do_sample(1'b0);

        // Random gates, tunings and idle gaps.
        for (int k = 0; k < 40; k++) begin
            for (int v = 0; v < NV; v++) begin
                m_on[v] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) m_inc[v] = longint'($urandom_range(0, 24'hFFFFFF));
            end
            apply_inputs();
            repeat ($urandom_range(0, 3)) step();
            do_sample(1'b0);
        end

        // Consumer stalls: second tick lands in HOLD and is lost.
        sample_ready = 1'b0;
        do_sample(1'b0);
        repeat (8) step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        exp_ovr = 1'b1;
        chk_val("bp_ovr",   longint'(overrun), 1);
        chk_val("bp_valid", longint'(sample_valid), 1);
        chk_val("bp_hold",  longint'(sample_out), last_exp);
        sample_ready = 1'b1;
        step();
        chk_val("bp_release", longint'(sample_valid), 0);
        do_sample(1'b0);

        // Reset clears the sticky flag; then a tick coincident with the handshake is dropped.
        reset_n = 1'b0;
        step();
        model_reset();
        chk_val("rst2_ovr", longint'(overrun), 0);
        reset_n = 1'b1;
        step();
        do_sample(1'b1);
        step();
        chk_val("hs_drop_busy",  longint'(busy), 0);
        chk_val("hs_drop_valid", longint'(sample_valid), 0);
        do_sample(1'b0);
        do_sample(1'b0);

        // Reset mid-RUN aborts the sample and restarts all phases.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk_val("abort_busy",  longint'(busy), 0);
        chk_val("abort_valid", longint'(sample_valid), 0);
        step();
        reset_n = 1'b1;
        model_reset();
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sample_valid) vcount++;
        end
        chk_val("abort_no_valid", vcount, 0);
        for (int k = 0; k < 4; k++) do_sample(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_tone_synth.md
# poly_tone_synth

Polyphonic, time-multiplexed tone synthesiser that replaces the fixed per-note square-wave instances in the piano top level. It produces one mixed signed sample per sample tick for `NUM_VOICES` independently tuned voices. Each voice has its own phase accumulator and linear attack/release envelope, so keys no longer click. It sits between the key/switch decode logic and the audio controller's left/right write port.

## Interface
- `NUM_VOICES`, 10, number of voices (2..32)
- `PHASE_W`, 24, phase accumulator / tuning word width
- `AMP_W`, 16, waveform and envelope width
- `OUT_W`, 32, output sample width
- `ENV_STEP`, 16, envelope increment/decrement per tick
- `MIX_SHIFT`, 0, left shift applied to the mix sum before saturation
- `Clk`  in  1  system clock (CLOCK_50)
- `reset_n`  in  1  asynchronous active-low reset
- `key_on`  in  NUM_VOICES  per-voice gate; 1 = attack/sustain, 0 = release
- `phase_inc`  in  NUM_VOICES*PHASE_W  tuning words; voice v is at bits [v*PHASE_W +: PHASE_W]
- `sample_tick`  in  1  one-cycle pulse at the sample rate
- `sample_out`  out  OUT_W  signed mixed sample
- `sample_valid`  out  1  sample_out is valid; held until accepted
- `sample_ready`  in  1  consumer accepts (audio_out_allowed)
- `overrun`  out  1  sticky; set when a tick is dropped
- `busy`  out  1  high in RUN and SAT

## Operation
- FSM states: IDLE, RUN, SAT, HOLD.
  - IDLE → RUN on `sample_tick`. The mix accumulator is cleared and voice index v = 0.
  - RUN processes one voice per cycle, v = 0..NUM_VOICES-1, then goes to SAT.
  - SAT registers the saturated sample, asserts `sample_valid` and goes to HOLD.
  - HOLD → IDLE on the cycle `sample_valid && sample_ready`.
- Per voice in RUN:
  - phase[v] += phase_inc[v], modulo 2^PHASE_W.
  - env[v]: if key_on[v], env = min(env + ENV_STEP, 2^AMP_W-1); otherwise env = max(env - ENV_STEP, 0).
  - wave uses the updated phase: phase MSB 0 → +(2^(AMP_W-1)-1), MSB 1 → -(2^(AMP_W-1)-1).
  - voice = (wave × env) >>> AMP_W. The shift is arithmetic (floor). env is unsigned.
  - acc += voice. The accumulator is signed, AMP_W+$clog2(NUM_VOICES)+1 bits wide, and never overflows.
- Saturation in SAT: `sample_out` = (acc <<< MIX_SHIFT) clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- `sample_tick` arriving in any state other than IDLE is dropped and sets `overrun`. Only `reset_n` clears `overrun`.
- A tick arriving in the same cycle as the HOLD→IDLE handshake is dropped.
- `key_on` and `phase_inc` are sampled in the RUN cycle that processes that voice. Changes mid-RUN affect later voices in the current sample.

## Timing
- Reset values, asynchronous: state = IDLE; all phase, env and acc = 0; `sample_out` = 0; `sample_valid` = 0; `overrun` = 0; `busy` = 0.
- Latency: a tick sampled at edge t gives `sample_valid` high after edge t+NUM_VOICES+1. For the default NUM_VOICES = 10, that is 11 cycles.
- `sample_out` is stable while `sample_valid` is high.
- Minimum tick spacing is NUM_VOICES+3 cycles when `sample_ready` is constantly high.
- Reset asserted mid-RUN or mid-HOLD aborts immediately. No partial sample is emitted.

## Configuration
- `PTS_SINE_EN` defined: wave comes from a quarter-wave sine lookup.
  - 64 entries, AMP_W-bit, peak 2^(AMP_W-1)-1.
  - Address is phase[PHASE_W-3 -: 6], mirrored when phase bit PHASE_W-2 = 1 and negated when the MSB = 1.
  - The lookup is combinational, so the latency is unchanged.
- `PTS_SINE_EN` undefined: square wave only, and no LUT is synthesised.

## Structure
- Package `pts_pkg` holds:
  - the default note tuning table for 48 kHz at PHASE_W = 24: C4..E5, e.g. C4 = 91446, A4 = 153791;
  - the FSM state enum;
  - the sine quarter-table constant.
- Sub-module `pts_voice_dp` is the per-voice datapath: phase add, envelope step, wave select and multiply. It is instantiated once and time-shared. Phase and envelope state are kept in register arrays in the parent.

## Test plan
- Reset: hold reset_n = 0, then release → sample_valid = 0, sample_out = 0, overrun = 0. Ticks then produce valid pulses 11 cycles after each tick.
- Single square voice: ENV_STEP = 65535, key_on[0] = 1, phase_inc[0] = 1048576, other voices off. Send 16 ticks with ready = 1 → sample_out = 32766 for ticks 1–7, -32767 for ticks 8–15, 32766 for tick 16.
- Envelope: ENV_STEP = 16, key_on[0] = 1 for 10 ticks, then 0 → env peaks at 160 and reaches 0 by tick 20. The sample is 0 from then on.
- Saturation: all 10 voices with equal tuning, full env, MIX_SHIFT = 16 → sample_out = 2147483647 on the positive half and -2147483648 on the negative half.
- Back-pressure: sample_ready = 0 and two ticks 20 cycles apart → the second tick is dropped, overrun = 1, sample_out is unchanged. Raising ready clears valid on the next edge.
- Reset mid-RUN: assert reset_n = 0 five cycles after a tick → state IDLE, valid never asserted, phases restart from 0.
